// File: rtl/nsadd_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
package nsadd_pkg;
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/nibble_serial_adder.sv
// Sequences a wide add through an external 4-bit adder, one nibble per cycle.
// Optional signed-overflow output enabled by defining NSADD_OVERFLOW_EN.
module nibble_serial_adder
    import nsadd_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W = NIB_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic             op_cin,
    output logic [NIB_W-1:0] add_a,
    output logic [NIB_W-1:0] add_b,
    output logic             add_cin,
    input  logic [NIB_W-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic             result_cout
`ifdef NSADD_OVERFLOW_EN
    ,
    output logic             result_ovf
`endif
);

    localparam int IDX_W = idx_width(NIBBLES);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_q, res_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_nib;

`ifdef NSADD_OVERFLOW_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
`ifdef NSADD_OVERFLOW_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = op_cin;
                    res_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef NSADD_OVERFLOW_EN
                    a_msb_d = op_a[W-1];
                    b_msb_d = op_b[W-1];
                    ovf_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                add_a   = a_q[NIB_W-1:0];
                add_b   = b_q[NIB_W-1:0];
                add_cin = carry_q;
                // Sum nibbles enter at the top so nibble 0 ends up at the bottom.
                res_d   = (res_q >> NIB_W)
                        | (W'(add_sum) << (W - NIB_W));
                carry_d = add_cout;
                a_d     = a_q >> NIB_W;
                b_d     = b_q >> NIB_W;
                idx_d   = idx_q + IDX_W'(1);
                if (last_nib) begin
                    state_d = DONE;
`ifdef NSADD_OVERFLOW_EN
                    ovf_d = (a_msb_q == b_msb_q)
                         && (add_sum[NIB_W-1] != a_msb_q);
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
`ifdef NSADD_OVERFLOW_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
`ifdef NSADD_OVERFLOW_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Held low during reset even though the state register already reads IDLE.
    assign in_ready    = rst_n && (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result      = res_q;
    assign result_cout = carry_q;
`ifdef NSADD_OVERFLOW_EN
    assign result_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with a behavioural 4-bit adder peer.
// Overflow checks are active when NSADD_OVERFLOW_EN is defined.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         result_cout;
`ifdef NSADD_OVERFLOW_EN
    logic         result_ovf;
`endif

    int total;
    int bad;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_cin     (op_cin),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_cout(result_cout)
`ifdef NSADD_OVERFLOW_EN
        ,
        .result_ovf (result_ovf)
`endif
    );

    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] er,
                          input logic ec, input logic eo);
        int n;
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        op_cin    = cin;
        out_ready = 1'b0;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_run", 32'(in_ready), 32'd0);
        chk("add_a_nib0", 32'(add_a), 32'(a[3:0]));
        chk("add_b_nib0", 32'(add_b), 32'(b[3:0]));
        chk("add_cin_nib0", 32'(add_cin), 32'(cin));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'd4);
        chk("result", 32'(result), 32'(er));
        chk("cout", 32'(result_cout), 32'(ec));
`ifdef NSADD_OVERFLOW_EN
        chk("ovf", 32'(result_ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unknown ovf expectation");
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    logic [W-1:0] ra[4];
    logic [W-1:0] rb[4];
    logic         rc[4];
    logic [W:0]   ref_sum;
    int sent, got, last, cyc;
    bit acc;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(result_cout), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Back-pressure: DONE must hold and refuse new operands.
        in_valid = 1'b1;
        op_a = 16'h0001; op_b = 16'h0002; op_cin = 1'b0;
        @(posedge clk); #1;
        op_a = 16'h1111; op_b = 16'h1111;
        repeat (4) @(posedge clk);
        #1;
        chk("hold_valid0", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_result", 32'(result), 32'h0003);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("next_taken", 32'(in_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("next_valid", 32'(out_valid), 32'd1);
        chk("next_result", 32'(result), 32'h2222);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of an operation.
        in_valid = 1'b1;
        op_a = 16'hAAAA; op_b = 16'h5555; op_cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_add_a", 32'(add_a), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0);

        // Streaming with both handshakes held high.
        for (int i = 0; i < 4; i++) begin
            ra[i] = W'($urandom);
            rb[i] = W'($urandom);
            rc[i] = 1'($urandom);
        end
        sent = 0; got = 0; last = 0; cyc = 0;
        out_ready = 1'b1;
        while (got < 4 && cyc < 200) begin
            acc = in_ready && (sent < 4);
            if (sent < 4) begin
                in_valid = 1'b1;
                op_a = ra[sent]; op_b = rb[sent]; op_cin = rc[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) sent++;
            if (out_valid) begin
                ref_sum = {1'b0, ra[got]} + {1'b0, rb[got]}
                        + (W+1)'(rc[got]);
                chk("stream_result", 32'(result), 32'(ref_sum[W-1:0]));
                chk("stream_cout", 32'(result_cout), 32'(ref_sum[W]));
                if (got > 0) chk("stream_gap", 32'(cyc - last), 32'd6);
                last = cyc;
                got++;
            end
        end
        chk("stream_count", 32'(got), 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
